// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, writeback control encoding,
// MEM-stage FSM states and the MEM/WB register payload.
package cpu_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int CPSR_W     = 7;
   localparam int WB_CTRL_W  = 2;

   localparam logic [WB_CTRL_W-1:0] WB_NONE = 2'b00;
   localparam logic [WB_CTRL_W-1:0] WB_ALU  = 2'b01;
   localparam logic [WB_CTRL_W-1:0] WB_LOAD = 2'b10;
   localparam logic [WB_CTRL_W-1:0] WB_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic [DATA_W-1:0]     result;
      logic [DATA_W-1:0]     mem_data;
      logic [WB_CTRL_W-1:0]  ctrl;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic [CPSR_W-1:0]     cpsr;
      logic                  fault;
   } mem_wb_t;

   // A bubble is an all-zero MEM/WB entry.
   function automatic mem_wb_t wb_bubble();
      return '0;
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: async reset, load enable, and bubble insertion
// that overrides the captured payload with an empty entry.
module mem_wb_reg
   import cpu_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t d,
   output mem_wb_t q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= wb_bubble();
      end else if (load) begin
         q <= bubble ? wb_bubble() : d;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: runs one load/store at a time over a req/ack
// bus, stalls upstream while it is outstanding and fills the MEM/WB register.
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     ex_alu_result,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [WB_CTRL_W-1:0]  ex_wb,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic [DATA_W-1:0]     ex_rs2_data,
   input  logic [CPSR_W-1:0]     ex_cpsr,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ack,
   output logic                  wb_valid,
   output logic [DATA_W-1:0]     wb_result,
   output logic [DATA_W-1:0]     wb_mem_data,
   output logic [WB_CTRL_W-1:0]  wb_ctrl,
   output logic [REG_ADDR_W-1:0] wb_rd_addr,
   output logic [CPSR_W-1:0]     wb_cpsr,
   output logic                  wb_fault
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  busy_cnt;
   logic              fault_flag;
   logic [DATA_W-1:0] load_data;

   logic access;
   logic ack_hit;
   logic expire;
   logic start;
   logic bubble;
   mem_wb_t wb_d, wb_q;

   assign access  = ex_mem_read | ex_mem_write;
   // Ack wins over an expiring counter in the same cycle.
   assign ack_hit = (state == ST_BUSY) & mem_ack;
   assign expire  = (state == ST_BUSY) & ~mem_ack & (busy_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (access) state_nxt = ST_BUSY;
         ST_BUSY: if (ack_hit | expire) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      stall  = 1'b0;
      start  = 1'b0;
      bubble = 1'b1;
      unique case (state)
         ST_IDLE: begin
            if (access) begin
               stall = 1'b1;
               start = 1'b1;
            end else begin
               bubble = 1'b0;
            end
         end
         ST_BUSY: stall  = 1'b1;
         ST_RESP: bubble = 1'b0;
         default: bubble = 1'b1;
      endcase
   end

   // Bus registers: address/data/we only change when a new request launches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (start) begin
         mem_req   <= 1'b1;
         mem_we    <= ex_mem_write;
         mem_addr  <= ex_alu_result;
         mem_wdata <= ex_rs2_data;
      end else if (ack_hit | expire) begin
         mem_req   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_cnt   <= '0;
         fault_flag <= 1'b0;
         load_data  <= '0;
      end else begin
         unique case (state)
            ST_BUSY: begin
               busy_cnt <= busy_cnt + CNT_W'(1);
               if (ack_hit) begin
                  load_data <= mem_we ? '0 : mem_rdata;
               end else if (expire) begin
                  fault_flag <= 1'b1;
                  load_data  <= '0;
               end
            end
            ST_RESP: begin
               busy_cnt   <= '0;
               fault_flag <= 1'b0;
               load_data  <= '0;
            end
            default: busy_cnt <= '0;
         endcase
      end
   end

   // The EX/MEM fields are still held in RESP because stall froze them.
   always_comb begin
      wb_d          = wb_bubble();
      wb_d.valid    = 1'b1;
      wb_d.result   = ex_alu_result;
      wb_d.ctrl     = ex_wb;
      wb_d.rd_addr  = ex_rd_addr;
      wb_d.cpsr     = ex_cpsr;
      if (state == ST_RESP) begin
         wb_d.mem_data = load_data;
         wb_d.fault    = fault_flag;
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk    (clk),
      .reset  (reset),
      .load   (1'b1),
      .bubble (bubble),
      .d      (wb_d),
      .q      (wb_q)
   );

   assign wb_valid    = wb_q.valid;
   assign wb_result   = wb_q.result;
   assign wb_mem_data = wb_q.mem_data;
   assign wb_ctrl     = wb_q.ctrl;
   assign wb_rd_addr  = wb_q.rd_addr;
   assign wb_cpsr     = wb_q.cpsr;
   assign wb_fault    = wb_q.fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each instruction is expanded into a
// per-cycle expectation timeline that a single compare process checks.
module tb_mem_access_unit;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ex_alu_result;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_wb;
   logic [2:0]  ex_rd_addr;
   logic [15:0] ex_rs2_data;
   logic [6:0]  ex_cpsr;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [15:0] wb_result;
   logic [15:0] wb_mem_data;
   logic [1:0]  wb_ctrl;
   logic [2:0]  wb_rd_addr;
   logic [6:0]  wb_cpsr;
   logic        wb_fault;

   mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .ex_alu_result (ex_alu_result),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_wb         (ex_wb),
      .ex_rd_addr    (ex_rd_addr),
      .ex_rs2_data   (ex_rs2_data),
      .ex_cpsr       (ex_cpsr),
      .stall         (stall),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .wb_valid      (wb_valid),
      .wb_result     (wb_result),
      .wb_mem_data   (wb_mem_data),
      .wb_ctrl       (wb_ctrl),
      .wb_rd_addr    (wb_rd_addr),
      .wb_cpsr       (wb_cpsr),
      .wb_fault      (wb_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [15:0] res;
      logic [15:0] md;
      logic [1:0]  ctrl;
      logic [2:0]  rd;
      logic [6:0]  cpsr;
      logic        fault;
   } wbx_t;

   typedef struct {
      logic [15:0] alu;
      logic        rd;
      logic        wr;
      logic [1:0]  wb;
      logic [2:0]  rda;
      logic [15:0] rs2;
      logic [6:0]  cpsr;
      logic        ack;
      logic [15:0] rdata;
      logic        e_stall;
      logic        e_req;
      logic        e_we;
      logic [15:0] e_addr;
      logic [15:0] e_wdata;
      wbx_t        e_wb;
   } cyc_t;

   cyc_t sched[$];
   cyc_t cur;
   wbx_t next_wb;
   logic live = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   stall_cycles = 0;
   int   req_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // The MEM/WB contents visible in a cycle are what the previous edge captured.
   task automatic push(input cyc_t c);
      c.e_wb = next_wb;
      sched.push_back(c);
   endtask

   task automatic add_alu(input logic [15:0] alu, input logic [1:0] wb, input logic [2:0] rda,
                          input logic [6:0] cpsr, input logic ack, input logic [15:0] rdata);
      cyc_t c;
      c = '{alu: alu, rd: 1'b0, wr: 1'b0, wb: wb, rda: rda, rs2: 16'h0, cpsr: cpsr,
            ack: ack, rdata: rdata, e_stall: 1'b0, e_req: 1'b0, e_we: 1'b0,
            e_addr: 16'h0, e_wdata: 16'h0, e_wb: '0};
      push(c);
      next_wb = {1'b1, alu, 16'h0000, wb, rda, cpsr, 1'b0};
   endtask

   // ack_k = BUSY cycle carrying the ack (0 or > TIMEOUT: never acked).
   task automatic add_mem(input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [1:0] wb, input logic [2:0] rda, input logic [15:0] wdata,
                          input logic [6:0] cpsr, input int ack_k, input logic [15:0] rdata);
      cyc_t        c;
      int          blen;
      logic        flt;
      logic [15:0] md;
      flt  = (ack_k < 1) || (ack_k > TIMEOUT);
      blen = flt ? TIMEOUT : ack_k;
      md   = (wr || flt) ? 16'h0000 : rdata;
      for (int j = 0; j <= blen + 1; j++) begin
         c = '{alu: addr, rd: rd, wr: wr, wb: wb, rda: rda, rs2: wdata, cpsr: cpsr,
               ack: 1'b0, rdata: 16'h5A5A, e_stall: 1'b0, e_req: 1'b0, e_we: wr,
               e_addr: addr, e_wdata: wdata, e_wb: '0};
         c.ack     = (j >= 1) && (j <= blen) && (j == ack_k);
         if (c.ack) c.rdata = rdata;
         c.e_stall = (j <= blen);
         c.e_req   = (j >= 1) && (j <= blen);
         push(c);
         if (j <= blen) next_wb = '0;
         else           next_wb = {1'b1, addr, md, wb, rda, cpsr, flt};
      end
   endtask

   task automatic run();
      stall_cycles = 0;
      req_cycles   = 0;
      while (sched.size() > 0) begin
         cur           = sched.pop_front();
         ex_alu_result = cur.alu;
         ex_mem_read   = cur.rd;
         ex_mem_write  = cur.wr;
         ex_wb         = cur.wb;
         ex_rd_addr    = cur.rda;
         ex_rs2_data   = cur.rs2;
         ex_cpsr       = cur.cpsr;
         mem_ack       = cur.ack;
         mem_rdata     = cur.rdata;
         live          = 1'b1;
         @(posedge clk);
         #1;
      end
      live = 1'b0;
   endtask

   always @(negedge clk) begin
      if (live) begin
         chk("stall", {31'b0, stall}, {31'b0, cur.e_stall});
         chk("mem_req", {31'b0, mem_req}, {31'b0, cur.e_req});
         if (cur.e_req) begin
            chk("mem_we", {31'b0, mem_we}, {31'b0, cur.e_we});
            chk("mem_addr", {16'b0, mem_addr}, {16'b0, cur.e_addr});
            chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, cur.e_wdata});
         end
         chk("wb_valid", {31'b0, wb_valid}, {31'b0, cur.e_wb.v});
         chk("wb_result", {16'b0, wb_result}, {16'b0, cur.e_wb.res});
         chk("wb_mem_data", {16'b0, wb_mem_data}, {16'b0, cur.e_wb.md});
         chk("wb_ctrl", {30'b0, wb_ctrl}, {30'b0, cur.e_wb.ctrl});
         chk("wb_rd_addr", {29'b0, wb_rd_addr}, {29'b0, cur.e_wb.rd});
         chk("wb_cpsr", {25'b0, wb_cpsr}, {25'b0, cur.e_wb.cpsr});
         chk("wb_fault", {31'b0, wb_fault}, {31'b0, cur.e_wb.fault});
         if (stall) stall_cycles++;
         if (mem_req) req_cycles++;
      end
   end

   initial begin
      reset = 1'b1;
      ex_alu_result = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_wb = '0;
      ex_rd_addr = '0; ex_rs2_data = '0; ex_cpsr = '0; mem_rdata = '0; mem_ack = 1'b0;
      next_wb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_wb_result", {16'b0, wb_result}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      reset = 1'b0;

      add_alu(16'h1234, 2'b01, 3'd3, 7'h15, 1'b0, 16'h0);
      run();
      chk("alu_valid", {31'b0, wb_valid}, 32'd1);
      chk("alu_result", {16'b0, wb_result}, 32'h1234);
      chk("alu_rd", {29'b0, wb_rd_addr}, 32'd3);
      chk("alu_stall_cycles", stall_cycles, 32'd0);

      add_mem(16'h0040, 1'b1, 1'b0, 2'b10, 3'd2, 16'h0000, 7'h01, 3, 16'hBEEF);
      run();
      chk("load_md", {16'b0, wb_mem_data}, 32'hBEEF);
      chk("load_valid", {31'b0, wb_valid}, 32'd1);
      chk("load_stall_cycles", stall_cycles, 32'd4);
      chk("load_req_cycles", req_cycles, 32'd3);

      add_mem(16'h0010, 1'b0, 1'b1, 2'b00, 3'd0, 16'h00AA, 7'h02, 1, 16'h1357);
      run();
      chk("store_md", {16'b0, wb_mem_data}, 32'd0);
      chk("store_stall_cycles", stall_cycles, 32'd2);
      chk("store_req_cycles", req_cycles, 32'd1);

      add_mem(16'h0100, 1'b1, 1'b0, 2'b10, 3'd4, 16'h0000, 7'h04, 0, 16'h0000);
      run();
      chk("tmo_fault", {31'b0, wb_fault}, 32'd1);
      chk("tmo_md", {16'b0, wb_mem_data}, 32'd0);
      chk("tmo_stall_cycles", stall_cycles, 32'd16);
      chk("tmo_req_cycles", req_cycles, 32'd15);

      add_mem(16'h0104, 1'b1, 1'b0, 2'b10, 3'd6, 16'h0000, 7'h08, 15, 16'hC0DE);
      run();
      chk("ack15_fault", {31'b0, wb_fault}, 32'd0);
      chk("ack15_md", {16'b0, wb_mem_data}, 32'hC0DE);

      add_mem(16'h0080, 1'b1, 1'b0, 2'b10, 3'd5, 16'h1111, 7'h02, 2, 16'h5555);
      add_mem(16'h0090, 1'b0, 1'b1, 2'b00, 3'd1, 16'h2222, 7'h03, 1, 16'h6666);
      add_mem(16'h00A0, 1'b1, 1'b1, 2'b00, 3'd7, 16'h7777, 7'h05, 2, 16'h9999);
      add_alu(16'h4321, 2'b01, 3'd2, 7'h7F, 1'b0, 16'h0);
      run();
      chk("b2b_stall_cycles", stall_cycles, 32'd8);
      chk("b2b_req_cycles", req_cycles, 32'd5);

      // Reset in the middle of an outstanding load.
      ex_alu_result = 16'h0300; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      ex_wb = 2'b10; ex_rd_addr = 3'd3; ex_cpsr = 7'h11; mem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
      chk("mid_rst_valid", {31'b0, wb_valid}, 32'd0);
      chk("mid_rst_result", {16'b0, wb_result}, 32'd0);
      chk("mid_rst_md", {16'b0, wb_mem_data}, 32'd0);
      chk("mid_rst_ctrl", {30'b0, wb_ctrl}, 32'd0);
      chk("mid_rst_rd", {29'b0, wb_rd_addr}, 32'd0);
      chk("mid_rst_cpsr", {25'b0, wb_cpsr}, 32'd0);
      chk("mid_rst_fault", {31'b0, wb_fault}, 32'd0);
      ex_mem_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      next_wb = '0;

      add_alu(16'h0001, 2'b01, 3'd1, 7'h00, 1'b1, 16'hFFFF);
      add_alu(16'h0002, 2'b01, 3'd2, 7'h00, 1'b1, 16'hFFFF);
      run();
      chk("stray_stall_cycles", stall_cycles, 32'd0);
      chk("stray_req_cycles", req_cycles, 32'd0);
      chk("stray_md", {16'b0, wb_mem_data}, 32'd0);
      chk("stray_result", {16'b0, wb_result}, 32'h0002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage access controller: consumes the EX/MEM pipeline register outputs, performs the data-memory load or store over a req/ack bus, stalls the upstream pipeline until the access completes, and registers the result into the MEM/WB stage. It sits between the EX/MEM register and writeback, and owns the MEM/WB register contents.

## Interface
Parameters:
- TIMEOUT, 15, max BUSY cycles without mem_ack before the access is aborted (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ex_alu_result  in  16  address for memory ops; pass-through result otherwise
- ex_mem_read  in  1  load request
- ex_mem_write  in  1  store request
- ex_wb  in  2  writeback control, passed through
- ex_rd_addr  in  3  destination register
- ex_rs2_data  in  16  store data
- ex_cpsr  in  7  ALU flags, passed through
- stall  out  1  hold EX/MEM and upstream registers (drives their write_enable low)
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = store, registered
- mem_addr  out  16  registered
- mem_wdata  out  16  registered
- mem_rdata  in  16  load data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe
- wb_valid  out  1  MEM/WB holds a real instruction
- wb_result  out  16  ALU result
- wb_mem_data  out  16  loaded data
- wb_ctrl  out  2  writeback control
- wb_rd_addr  out  3
- wb_cpsr  out  7
- wb_fault  out  1  access timed out

## Operation
- FSM states: IDLE, BUSY, RESP.
- Access present = ex_mem_read | ex_mem_write. When both are set, the access is a store (write priority).
- IDLE, no access: stall=0; on the clock edge, MEM/WB captures the ex_* inputs, wb_valid=1, wb_mem_data=0.
- IDLE, access present: stall=1; on the edge, latch addr/wdata/we, set mem_req=1, go to BUSY; MEM/WB captures a bubble.
- BUSY: stall=1; mem_req held high; the timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata, clear mem_req, go to RESP.
  - Counter reaches TIMEOUT without ack: clear mem_req, set the fault flag, load data = 0, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no fault.
- RESP: stall=0; on the edge, MEM/WB captures the still-held ex_* fields plus the load data, with wb_valid=1 and wb_fault = fault flag. Go to IDLE and clear the counter and fault flag. RESP never starts a new access.
- Bubble: wb_valid=0, wb_ctrl=0, wb_fault=0; other wb_* fields are zero.
- mem_ack outside BUSY is ignored.
- wb_mem_data is the captured mem_rdata for loads and 0 for stores.

## Timing
- Reset (async): state IDLE; counter 0; mem_req/mem_we/mem_addr/mem_wdata = 0; all wb_* = 0.
- stall is combinational: (IDLE & access present) | BUSY. It is 0 in RESP.
- Non-memory instruction: 1-cycle latency, no stall.
- Ack on the k-th BUSY cycle (k≥1): stall is high for k+1 cycles, and the instruction occupies the stage for k+2 cycles.
- Timeout: BUSY lasts exactly TIMEOUT cycles; stall is high for TIMEOUT+1 cycles.
- mem_req rises on the edge leaving IDLE and falls on the edge leaving BUSY. mem_addr, mem_wdata and mem_we are stable while mem_req=1.
- Reset mid-access: mem_req drops immediately, any in-flight access is abandoned, and no fault is reported.

## Structure
- Shared package cpu_pkg: state enum, DATA_W=16, REG_ADDR_W=3, CPSR_W=7, WB control encoding.
- Sub-module: mem_wb_reg, the MEM/WB pipeline register with async reset, load enable and bubble insert.
- The FSM, counter and bus registers live in mem_access_unit.

## Test plan
- ALU op (ex_alu_result=16'h1234, ex_wb=2'b01, rd=3) → next edge: wb_valid=1, wb_result=16'h1234, wb_rd_addr=3; stall never high.
- Load addr 16'h0040, ack on 3rd BUSY cycle with rdata 16'hBEEF → mem_req high 3 cycles, stall high 4 cycles, then wb_mem_data=16'hBEEF, wb_valid=1, bubbles (wb_valid=0) in between.
- Store addr 16'h0010, data 16'h00AA, ack on 1st BUSY cycle → mem_we=1, mem_wdata=16'h00AA, stall 2 cycles, wb_mem_data=0.
- No ack, TIMEOUT=15 → mem_req drops after 15 BUSY cycles, wb_fault=1 for one instruction, wb_mem_data=0; ack on cycle 15 instead → wb_fault=0.
- Reset asserted during BUSY → mem_req=0 and all wb_*=0 immediately; after release, state IDLE and a stray mem_ack is ignored.
- Back-to-back load then store, plus ex_mem_read=ex_mem_write=1 → each access is serviced in order, the dual-flag case issues mem_we=1, and no request overlaps.
